// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
// Interrupt/status stage behind the 8-bit timer counter. Rising edges of the
// counter's overflow/underflow flags set sticky pending bits. Per-source
// enables gate the interrupt line, which runs in level or single-pulse mode.
// A single-cycle register port exposes CTRL, STATUS (W1C) and MISS.
//
// Optional feature macro: TIMER_IRQ_MISS_CNT_EN
//   defined   : address 2 is an 8-bit saturating count of events lost
//               because their pending bit was already set; any write clears it
//   undefined : address 2 reads 0, writes ignored
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   overflow   counter overflow flag (level)
//   underflow  counter underflow flag (level)
//   reg_wr     write strobe
//   reg_rd     read strobe
//   reg_addr   register select (0 CTRL, 1 STATUS, 2 MISS, 3 reserved)
//   reg_wdata  write data
//   reg_rdata  registered read data, held until the next read
//   irq        interrupt output (registered)
module timer_irq_ctrl #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              overflow,
  input  logic              underflow,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_MISS = ADDR_W'(2);

  logic       ovf_dly_q, udf_dly_q;
  logic [1:0] ie_q, ie_d;
  logic       pulse_q, pulse_d;
  logic [1:0] pend_q, pend_d;
  logic       any_prev_q;
  logic       irq_q, irq_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] miss_rd;

  logic [1:0] ev;
  logic [1:0] clr;
  logic       any_masked;
  logic       wr_ctrl, wr_stat;

  assign ev      = {underflow & ~udf_dly_q, overflow & ~ovf_dly_q};
  assign wr_ctrl = reg_wr && (reg_addr == A_CTRL);
  assign wr_stat = reg_wr && (reg_addr == A_STAT);
  assign clr     = wr_stat ? reg_wdata[1:0] : 2'b00;

  // A new event beats a same-edge clear.
  assign pend_d = (pend_q & ~clr) | ev;

  assign ie_d    = wr_ctrl ? reg_wdata[1:0] : ie_q;
  assign pulse_d = wr_ctrl ? reg_wdata[2]   : pulse_q;

  // any_prev_q tracks the masked value in both modes, so entering pulse mode
  // with something already pending does not produce a pulse.
  assign any_masked = |(pend_q & ie_q);
  assign irq_d      = pulse_q ? (any_masked & ~any_prev_q) : any_masked;

`ifdef TIMER_IRQ_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;
  logic [1:0] miss_ev;
  logic [8:0] miss_sum;
  logic       wr_miss;

  assign wr_miss  = reg_wr && (reg_addr == A_MISS);
  // An event that coincides with its own W1C is a fresh event, not a miss.
  assign miss_ev  = ev & pend_q & ~clr;
  assign miss_sum = {1'b0, miss_q} + {8'b0, miss_ev[0]} + {8'b0, miss_ev[1]};
  assign miss_d   = wr_miss ? 8'h00 : (miss_sum[8] ? 8'hFF : miss_sum[7:0]);
  assign miss_rd  = miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_q <= 8'h00;
    else     miss_q <= miss_d;
  end
`else
  assign miss_rd = 8'h00;
`endif

  logic unused_wdata;
  assign unused_wdata = &{1'b0, reg_wdata[7:3]};

  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd) begin
      case (reg_addr)
        A_CTRL:  rdata_d = {5'b0, pulse_q, ie_q};
        A_STAT:  rdata_d = {6'b0, pend_q};
        A_MISS:  rdata_d = miss_rd;
        default: rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_dly_q  <= 1'b0;
      udf_dly_q  <= 1'b0;
      ie_q       <= 2'b00;
      pulse_q    <= 1'b0;
      pend_q     <= 2'b00;
      any_prev_q <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      ovf_dly_q  <= overflow;
      udf_dly_q  <= underflow;
      ie_q       <= ie_d;
      pulse_q    <= pulse_d;
      pend_q     <= pend_d;
      any_prev_q <= any_masked;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       overflow, underflow;
  logic       reg_wr, reg_rd;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       irq;
  logic       chk_irq;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t rd_sb[$];
  exp_t irq_sb[$];

  timer_irq_ctrl #(.ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .overflow  (overflow),
    .underflow (underflow),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endtask

  // Monitor: whatever the stimulus marked for the edge just taken is popped
  // from its scoreboard and compared shortly after that edge.
  initial begin : monitor
    logic s_rd, s_ci;
    exp_t e;
    forever begin
      @(posedge clk);
      s_rd = reg_rd;
      s_ci = chk_irq;
      #1;
      if (s_rd) begin
        if (rd_sb.size() == 0) chk("rd_sb_underflow", 8'h01, 8'h00);
        else begin
          e = rd_sb.pop_front();
          chk(e.name, reg_rdata, e.exp);
        end
      end
      if (s_ci) begin
        if (irq_sb.size() == 0) chk("irq_sb_underflow", 8'h01, 8'h00);
        else begin
          e = irq_sb.pop_front();
          chk(e.name, {7'b0, irq}, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic nxt();
    @(negedge clk);
    reg_wr  = 1'b0;
    reg_rd  = 1'b0;
    chk_irq = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    nxt();
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string name);
    nxt();
    reg_rd   = 1'b1;
    reg_addr = a;
    rd_sb.push_back('{e, name});
  endtask

  // Expect irq == e right after the coming rising edge.
  task automatic ci(input logic e, input string name);
    chk_irq = 1'b1;
    irq_sb.push_back('{{7'b0, e}, name});
  endtask

  task automatic ovf_pulse();
    nxt(); overflow = 1'b1;
    nxt(); overflow = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1; overflow = 1'b0; underflow = 1'b0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 2'd0; reg_wdata = 8'h00;
    chk_irq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd(2'd0, 8'h00, "rst_ctrl");
    rd(2'd1, 8'h00, "rst_status");
    rd(2'd2, 8'h00, "rst_miss");
    rd(2'd3, 8'h00, "rst_rsvd");
    nxt(); ci(1'b0, "rst_irq");

    // Level mode, overflow held 5 cycles
    wr(2'd0, 8'h01);
    nxt(); overflow = 1'b1; ci(1'b0, "lvl_irq_edge_k");
    nxt(); ci(1'b1, "lvl_irq_edge_k1");
    nxt(); ci(1'b1, "lvl_irq_hold2");
    nxt(); ci(1'b1, "lvl_irq_hold3");
    nxt(); ci(1'b1, "lvl_irq_hold4");
    nxt(); overflow = 1'b0;
    rd(2'd1, 8'h01, "lvl_status_one_event");
    wr(2'd1, 8'h01); ci(1'b1, "w1c_irq_same_edge");
    nxt(); ci(1'b0, "w1c_irq_next_edge");
    rd(2'd1, 8'h00, "w1c_status");

    // Pulse mode, both sources together
    wr(2'd0, 8'h07);
    nxt(); overflow = 1'b1; underflow = 1'b1; ci(1'b0, "pls_edge_k");
    nxt(); ci(1'b1, "pls_edge_k1");
    nxt(); ci(1'b0, "pls_edge_k2");
    nxt(); overflow = 1'b0; underflow = 1'b0; ci(1'b0, "pls_edge_k3");
    rd(2'd1, 8'h03, "pls_status_both");
    wr(2'd1, 8'h01); ci(1'b0, "pls_partial_clr");
    nxt(); ci(1'b0, "pls_partial_clr_next");
    rd(2'd1, 8'h02, "pls_status_after_clr");

    // Same-edge underflow rise and W1C of its bit: set wins
    nxt(); underflow = 1'b1; reg_wr = 1'b1; reg_addr = 2'd1; reg_wdata = 8'h02;
    ci(1'b0, "setwin_irq");
    nxt(); underflow = 1'b0;
    rd(2'd1, 8'h02, "setwin_status");
    wr(2'd1, 8'h03);
    rd(2'd1, 8'h00, "clear_all");

    // Disabled source still pends; enabling later raises irq
    wr(2'd0, 8'h00);
    ovf_pulse();
    nxt(); ci(1'b0, "dis_irq_low");
    rd(2'd1, 8'h01, "dis_status");
    wr(2'd0, 8'h01); ci(1'b0, "en_irq_same_edge");
    nxt(); ci(1'b1, "en_irq_next_edge");

    // Mode switching with a pending masked source
    wr(2'd0, 8'h05); ci(1'b1, "to_pulse_edge_k");
    nxt(); ci(1'b0, "to_pulse_no_pulse");
    nxt(); ci(1'b0, "to_pulse_quiet");
    wr(2'd0, 8'h01); ci(1'b0, "to_level_edge_k");
    nxt(); ci(1'b1, "to_level_edge_k1");
    wr(2'd1, 8'h01);
    nxt(); ci(1'b0, "lvl_clear_irq");

    // Same-edge read and write return the pre-write value
    nxt(); reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 2'd0; reg_wdata = 8'hFE;
    rd_sb.push_back('{8'h01, "rdwr_prewrite"});
    rd(2'd0, 8'h06, "ctrl_masked_bits");
    wr(2'd3, 8'hFF);
    rd(2'd3, 8'h00, "rsvd_write_ignored");

`ifdef TIMER_IRQ_MISS_CNT_EN
    wr(2'd0, 8'h00);
    repeat (3) ovf_pulse();
    rd(2'd2, 8'h02, "miss_two");
    repeat (297) ovf_pulse();
    rd(2'd2, 8'hFF, "miss_saturate");
    wr(2'd2, 8'h5A);
    rd(2'd2, 8'h00, "miss_cleared");
    nxt(); underflow = 1'b1;
    nxt(); underflow = 1'b0;
    nxt(); overflow = 1'b1; underflow = 1'b1;
    nxt(); overflow = 1'b0; underflow = 1'b0;
    rd(2'd2, 8'h02, "miss_both_add2");
    nxt(); overflow = 1'b1; reg_wr = 1'b1; reg_addr = 2'd2; reg_wdata = 8'h00;
    nxt(); overflow = 1'b0;
    rd(2'd2, 8'h00, "miss_on_clear_edge");
    nxt(); overflow = 1'b1; reg_wr = 1'b1; reg_addr = 2'd1; reg_wdata = 8'h01;
    nxt(); overflow = 1'b0;
    rd(2'd2, 8'h00, "miss_w1c_not_miss");
    rd(2'd1, 8'h03, "miss_status");
`else
    wr(2'd2, 8'hFF);
    ovf_pulse();
    ovf_pulse();
    rd(2'd2, 8'h00, "miss_absent");
`endif

    // Asynchronous reset kills an in-flight pulse
    wr(2'd1, 8'h03);
    wr(2'd0, 8'h05);
    nxt(); overflow = 1'b1;
    nxt(); overflow = 1'b0;
    @(posedge clk); #1;
    chk("pulse_before_rst", {7'b0, irq}, 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_irq", {7'b0, irq}, 8'h00);
    chk("rst_async_rdata", reg_rdata, 8'h00);
    nxt(); rst = 1'b0;
    rd(2'd0, 8'h00, "post_rst_ctrl");
    rd(2'd1, 8'h00, "post_rst_status");
    nxt(); ci(1'b0, "post_rst_irq");

    repeat (3) nxt();
    chk("sb_drain", 8'(rd_sb.size() + irq_sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
